// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

  localparam int BW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int bw = BW_DEFAULT
);

  logic            start;
  logic [2*bw-1:0] dividend;
  logic [bw-1:0]   divisor;
  logic [2*bw-1:0] quotient;
  logic [bw-1:0]   remainder;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_divider_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_restoring_step
  import seq_divider_pkg::*;
#(
  parameter int bw = BW_DEFAULT
) (
  input  logic [bw:0]   partial,
  input  logic          din,
  input  logic [bw-1:0] divisor,
  output logic [bw:0]   partial_next,
  output logic          q_bit
);

  logic [bw+1:0] shifted;
  logic [bw+1:0] diff;

  // partial[bw] is always 0 (partial < divisor), so the extra top bit only
  // carries the borrow of the bw+1-bit trial subtraction.
  always_comb begin
    shifted      = {partial, din};
    diff         = shifted - {2'b00, divisor};
    q_bit        = ~diff[bw+1];
    partial_next = q_bit ? diff[bw:0] : shifted[bw:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: 2*bw-bit dividend / bw-bit divisor, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int bw = BW_DEFAULT
) (
  input logic          CLK,
  input logic          RESETn,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(2*bw);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*bw-1:0]  dshift;
  logic [2*bw-2:0]  qshift;
  logic [bw-1:0]    dvsr;
  logic [bw:0]      partial;
  logic [bw:0]      partial_next;
  logic             q_bit;
  logic             accept;

  div_restoring_step #(.bw(bw)) u_step (
    .partial      (partial),
    .din          (dshift[2*bw-1]),
    .divisor      (dvsr),
    .partial_next (partial_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        accept = bus.start;
        if (bus.start)           state_n = (bus.divisor == '0) ? DONE : CALC;
        else if (state == DONE)  state_n = IDLE;
      end
      CALC:    if (cnt == '0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cnt             <= '0;
      dshift          <= '0;
      qshift          <= '0;
      dvsr            <= '0;
      partial         <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        if (bus.divisor == '0) begin
          bus.quotient    <= '1;
          bus.remainder   <= '0;
          bus.div_by_zero <= 1'b1;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
        end else begin
          dshift   <= bus.dividend;
          dvsr     <= bus.divisor;
          partial  <= '0;
          qshift   <= '0;
          cnt      <= CNT_W'(2*bw-1);
          bus.busy <= 1'b1;
        end
      end else if (state == CALC) begin
        partial <= partial_next;
        dshift  <= dshift << 1;
        qshift  <= {qshift[2*bw-3:0], q_bit};
        cnt     <= cnt - 1'b1;
        // Results land in the output registers only on the final step so
        // previous results stay visible for the whole calculation.
        if (cnt == '0) begin
          bus.quotient    <= {qshift, q_bit};
          bus.remainder   <= partial_next[bw-1:0];
          bus.div_by_zero <= 1'b0;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle model from plain division plus directed literal checks.
module tb_seq_divider;

  localparam int BW = 16;

  logic CLK;
  logic RESETn;
  int   checks;
  int   errors;
  bit   chk_en;

  seq_divider_if #(.bw(BW)) bus ();

  seq_divider #(.bw(BW)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a result is due 2*BW edges after an accepted start.
  logic [31:0] m_q, p_q;
  logic [15:0] m_r, p_r;
  logic        m_busy, m_done, m_dbz;
  int          m_left;

  always @(posedge CLK) begin
    if (!RESETn) begin
      m_q = '0; m_r = '0; m_busy = 0; m_done = 0; m_dbz = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 0;
        end
      end else if (bus.start) begin
        if (bus.divisor == 0) begin
          m_q = 32'hFFFF_FFFF; m_r = 0; m_dbz = 1; m_done = 1;
        end else begin
          p_q = bus.dividend / {16'd0, bus.divisor};
          p_r = 16'(bus.dividend % {16'd0, bus.divisor});
          m_left = 2*BW; m_busy = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_busy", 64'(bus.busy), 64'(m_busy));
      check("model_done", 64'(bus.done), 64'(m_done));
      check("model_dbz",  64'(bus.div_by_zero), 64'(m_dbz));
      check("model_quot", 64'(bus.quotient), 64'(m_q));
      check("model_rem",  64'(bus.remainder), 64'(m_r));
    end
  end

  // Issue one operation from an IDLE or DONE cycle and wait for its done.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] eq, input logic [15:0] er, input bit ez,
                       input int elat, input string name);
    int lat, nbusy;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    lat = 0; nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge CLK); #1;
      lat++;
    end
    check({name, "_lat"},  64'(lat), 64'(elat));
    check({name, "_busy"}, 64'(nbusy), 64'(elat));
    check({name, "_q"},    64'(bus.quotient), 64'(eq));
    check({name, "_r"},    64'(bus.remainder), 64'(er));
    check({name, "_dbz"},  64'(bus.div_by_zero), 64'(ez));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, dvd;
    logic [15:0] dvs;
    int          lat, ndone;
    checks = 0; errors = 0; chk_en = 0;
    RESETn = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge CLK);
    #1; chk_en = 1;
    check("rst_q",    64'(bus.quotient), 64'd0);
    check("rst_r",    64'(bus.remainder), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    do_op(32'd100000, 16'd7, 32'd14285, 16'd5, 1'b0, 32, "t100000_7");
    @(posedge CLK); #1;
    do_op(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 32, "tmax_max");
    do_op(32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 32, "tmax_1");
    do_op(32'd1234, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 0, "tdbz");
    @(posedge CLK); #1;
    check("dbz_done_pulse", 64'(bus.done), 64'd0);
    check("dbz_hold", 64'(bus.div_by_zero), 64'd1);
    do_op(32'd0, 16'd5, 32'd0, 16'd0, 1'b0, 32, "tzero_dvd");

    // Start re-pulse during CALC must be ignored.
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd3;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge CLK); #1; lat++; end
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd10;
    @(posedge CLK); #1; lat++;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    while (!bus.done && lat < 40) begin @(posedge CLK); #1; lat++; end
    check("ign_lat", 64'(lat), 64'd32);
    check("ign_q",   64'(bus.quotient), 64'd16);
    check("ign_r",   64'(bus.remainder), 64'd2);
    do_op(32'd9, 16'd4, 32'd2, 16'd1, 1'b0, 32, "tb2b_9_4");

    // Reset mid-calculation aborts without a done.
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (14) begin @(posedge CLK); #1; end
    RESETn = 1'b0;
    @(posedge CLK); #1;
    check("mid_rst_q",    64'(bus.quotient), 64'd0);
    check("mid_rst_r",    64'(bus.remainder), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    RESETn = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge CLK); #1; if (bus.done) ndone++; end
    check("mid_rst_nodone", 64'(ndone), 64'd0);
    do_op(32'd81, 16'd9, 32'd9, 16'd0, 1'b0, 32, "t81_9");

    for (int i = 0; i < 1000; i++) begin
      a = 32'($urandom_range(0, 65535));
      b = 32'($urandom_range(1, 65535));
      do_op(a * b, b[15:0], a, 16'd0, 1'b0, 32, "rt");
    end

    for (int i = 0; i < 200; i++) begin
      dvd = $urandom;
      dvs = 16'($urandom_range(1, 65535));
      do_op(dvd, dvs, dvd / {16'd0, dvs}, 16'(dvd % {16'd0, dvs}), 1'b0, 32, "rnd");
      check("rnd_recon", 64'(bus.quotient) * 64'(dvs) + 64'(bus.remainder), 64'(dvd));
      check("rnd_rltd", 64'(bus.remainder < dvs), 64'd1);
    end

    @(posedge CLK); #1;
    @(posedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
